// File: rtl/key_debounce_sel.sv
// Key front end. Each raw active-low key is synchronised, debounced and turned into
// clean level and press/release pulses. A priority-encoded tone select code is registered.
module key_debounce_lane #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = $clog2(DB_CYCLES+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o
);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          prs_q, prs_d;
  logic          rel_q, rel_d;
  logic          pressed;

  assign pressed = ~sync_q[1];

  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    prs_d = 1'b0;
    rel_d = 1'b0;
    // Any agreement clears the count, so only an unbroken run of disagreement flips the level
    if (pressed != lvl_q) begin
      if (cnt_q == CW'(DB_CYCLES-1)) begin
        lvl_d = ~lvl_q;
        prs_d = ~lvl_q;
        rel_d = lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      prs_q  <= 1'b0;
      rel_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      prs_q  <= prs_d;
      rel_q  <= rel_d;
    end
  end

  assign level_o = lvl_q;
  assign press_o = prs_q;
  assign rel_o   = rel_q;
endmodule

module key_debounce_sel #(
  parameter int N_KEYS    = 5,
  parameter int DB_CYCLES = 1_000_000,
  parameter int HOLD      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [2:0]        tone_sel,
  output logic              sel_valid
);
  logic [2:0] tone_q, tone_d;
  logic [2:0] pick;
  logic       vld_q, vld_d;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_debounce_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .key_n_i (key[g]),
      .level_o (key_level[g]),
      .press_o (key_press[g]),
      .rel_o   (key_release[g])
    );
  end

  always_comb begin
    pick = '0;
    // Scan high to low so the lowest pressed index wins
    for (int i = N_KEYS-1; i >= 0; i--)
      if (key_press[i]) pick = 3'(i+1);
    tone_d = tone_q;
    if (|key_press)
      tone_d = pick;
    else if (HOLD == 0 && key_level == '0 && tone_q != 3'd0)
      tone_d = 3'd0;
    vld_d = (tone_d != tone_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_q <= 3'd0;
      vld_q  <= 1'b0;
    end else begin
      tone_q <= tone_d;
      vld_q  <= vld_d;
    end
  end

  assign tone_sel  = tone_q;
  assign sel_valid = vld_q;
endmodule

// File: tb/tb_key_debounce_sel.sv
// Directed bench for key_debounce_sel with DB_CYCLES=4; a HOLD=0 and a HOLD=1 instance.
module tb_key_debounce_sel;
  localparam int NK = 5;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_a, key_b;
  logic [NK-1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
  logic [2:0]    tone_a, tone_b;
  logic          sv_a, sv_b;

  int n_chk = 0;
  int n_fail = 0;
  int pa[NK], ra[NK], ph[NK], rh[NK];
  int sva = 0, svh = 0;
  int s_p[NK], s_r[NK];
  int s_sv;

  always #5 clk = ~clk;

  key_debounce_sel #(.N_KEYS(NK), .DB_CYCLES(DB), .HOLD(0)) dut (
    .clk(clk), .rst(rst), .key(key_a), .key_level(lvl_a), .key_press(prs_a),
    .key_release(rel_a), .tone_sel(tone_a), .sel_valid(sv_a)
  );

  key_debounce_sel #(.N_KEYS(NK), .DB_CYCLES(DB), .HOLD(1)) dut_h (
    .clk(clk), .rst(rst), .key(key_b), .key_level(lvl_b), .key_press(prs_b),
    .key_release(rel_b), .tone_sel(tone_b), .sel_valid(sv_b)
  );

  initial begin
    for (int i = 0; i < NK; i++) begin pa[i] = 0; ra[i] = 0; ph[i] = 0; rh[i] = 0; end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      pa[i] += int'(prs_a[i]);
      ra[i] += int'(rel_a[i]);
      ph[i] += int'(prs_b[i]);
      rh[i] += int'(rel_b[i]);
    end
    sva += int'(sv_a);
    svh += int'(sv_b);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap_a();
    for (int i = 0; i < NK; i++) begin s_p[i] = pa[i]; s_r[i] = ra[i]; end
    s_sv = sva;
  endtask

  task automatic snap_b();
    for (int i = 0; i < NK; i++) begin s_p[i] = ph[i]; s_r[i] = rh[i]; end
    s_sv = svh;
  endtask

  initial begin
    rst = 1'b1; key_a = '1; key_b = '1;
    step(3);
    chk("rst_level", int'(lvl_a), 0);
    chk("rst_press", int'(prs_a), 0);
    chk("rst_tone", int'(tone_a), 0);
    chk("rst_sv", int'(sv_a), 0);
    rst = 1'b0;
    step(4);

    // 1: clean press of key0, exact latency
    key_a[0] = 1'b0;
    step(5);
    chk("t1_level_early", int'(lvl_a[0]), 0);
    step(1);
    chk("t1_level", int'(lvl_a[0]), 1);
    chk("t1_press", int'(prs_a[0]), 1);
    chk("t1_tone_early", int'(tone_a), 0);
    step(1);
    chk("t1_press_end", int'(prs_a[0]), 0);
    chk("t1_tone", int'(tone_a), 1);
    chk("t1_sv", int'(sv_a), 1);
    step(1);
    chk("t1_sv_end", int'(sv_a), 0);

    // 2: bouncing press of key1
    snap_a();
    key_a[1] = 1'b0; step(3);
    key_a[1] = 1'b1; step(1);
    key_a[1] = 1'b0; step(12);
    chk("t2_press_cnt", pa[1] - s_p[1], 1);
    chk("t2_rel_cnt", ra[1] - s_r[1], 0);
    chk("t2_tone", int'(tone_a), 2);
    chk("t2_sv_cnt", sva - s_sv, 1);
    snap_a();
    key_a[1:0] = 2'b11; step(12);
    chk("t2_rel0", ra[0] - s_r[0], 1);
    chk("t2_rel1", ra[1] - s_r[1], 1);
    chk("t2_tone_off", int'(tone_a), 0);

    // 3: glitch shorter than DB_CYCLES
    snap_a();
    key_a[3] = 1'b0; step(3);
    key_a[3] = 1'b1; step(12);
    chk("t3_press_cnt", pa[3] - s_p[3], 0);
    chk("t3_rel_cnt", ra[3] - s_r[3], 0);
    chk("t3_level", int'(lvl_a), 0);
    chk("t3_tone", int'(tone_a), 0);
    chk("t3_sv_cnt", sva - s_sv, 0);

    // 4: simultaneous press of key2 and key4, then release both
    snap_a();
    key_a[2] = 1'b0; key_a[4] = 1'b0; step(8);
    chk("t4_press2", pa[2] - s_p[2], 1);
    chk("t4_press4", pa[4] - s_p[4], 1);
    chk("t4_level", int'(lvl_a), 5'b10100);
    chk("t4_tone", int'(tone_a), 3);
    chk("t4_sv_cnt", sva - s_sv, 1);
    key_a[2] = 1'b1; key_a[4] = 1'b1; step(8);
    chk("t4_tone_off", int'(tone_a), 0);
    chk("t4_sv_cnt2", sva - s_sv, 2);
    chk("t4_level_off", int'(lvl_a), 0);

    // 5: HOLD=1 keeps selection through release; re-press gives no sel_valid
    key_b[0] = 1'b0; step(8);
    chk("t5_tone", int'(tone_b), 1);
    snap_b();
    key_b[0] = 1'b1; step(8);
    chk("t5_level_off", int'(lvl_b[0]), 0);
    chk("t5_rel_cnt", rh[0] - s_r[0], 1);
    chk("t5_tone_hold", int'(tone_b), 1);
    chk("t5_sv_rel", svh - s_sv, 0);
    key_b[0] = 1'b0; step(8);
    chk("t5_repress", ph[0] - s_p[0], 1);
    chk("t5_sv_repress", svh - s_sv, 0);
    chk("t5_tone_again", int'(tone_b), 1);

    // 6: reset in the middle of a key0 debounce
    key_a[0] = 1'b0; step(2);
    rst = 1'b1; step(2);
    chk("t6_rst_level", int'(lvl_a), 0);
    chk("t6_rst_press", int'(prs_a), 0);
    chk("t6_rst_tone", int'(tone_a), 0);
    chk("t6_rst_sv", int'(sv_a), 0);
    chk("t6_rst_tone_h", int'(tone_b), 0);
    rst = 1'b0;
    step(5);
    chk("t6_press_early", int'(prs_a[0]), 0);
    step(1);
    chk("t6_press", int'(prs_a[0]), 1);
    chk("t6_level", int'(lvl_a[0]), 1);
    step(1);
    chk("t6_tone", int'(tone_a), 1);
    chk("t6_sv", int'(sv_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
